serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around the team's existing `full_adder` cell.
- Accepts two operands and a carry-in on a start pulse.
- Sums one bit per clock, LSB first, using a registered carry.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Sits directly downstream of operand sources and directly upstream of the `full_adder` stage, feeding it one bit per cycle.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- busy  output  1  high while state is RUN or DONE.
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle onward.
- sum  output  WIDTH  registered result, held until the next completion.
- cout  output  1  registered final carry, held until the next completion.

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous, active-low.
- Reset: state=IDLE; shift regs, carry FF, counter, sum, cout, done, busy all 0. Release is synchronous to clk.
- States:
  - IDLE -> RUN on start=1.
  - RUN -> DONE when counter==WIDTH-1 at the edge.
  - DONE -> IDLE unconditionally.
- Accept edge (IDLE, start=1):
  - sha<=a, shb<=b, carry<=cin, cnt<=0, partial<=0.
- Each RUN edge:
  - The full_adder instance sees sha[0], shb[0], carry.
  - sha, shb shift right one bit.
  - partial shifts right with the FA sum bit entering at MSB.
  - carry<=FA carry; cnt<=cnt+1.
- RUN->DONE edge: sum<=final partial, including the last bit; cout<=final FA carry; done<=1.
- DONE cycle: done=1 for exactly one cycle, then 0 on the DONE->IDLE edge.
- Latency:
  - start accepted at edge 0.
  - WIDTH RUN edges follow (edges 1..WIDTH).
  - done is high in the cycle after edge WIDTH.
  - Next start is accepted at edge WIDTH+2 at the earliest.
- Arithmetic: {cout,sum} == a + b + cin exactly, mod 2^(WIDTH+1). No overflow flag.
- start while busy (RUN or DONE): ignored, with no effect on the operation in flight. a/b/cin changes during RUN: no effect.
- sum/cout hold their previous result throughout RUN. They never show partial values.
- Back-to-back: start held high continuously gives one addition every WIDTH+2 cycles.
- Reset mid-RUN: aborts immediately. Outputs return to reset values; no done pulse.
- Counter never exceeds WIDTH-1 in RUN. No wrap.
- busy is combinational from the state register only (no input paths).

Decomposition:
- Shared package `adder_pkg`: state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2. 2'd3 is illegal and recovers to IDLE.
- One sub-module: the existing `full_adder` (a,b,cin -> sum,carry), instantiated once. No new sub-modules.

Test Plan:
- Reset then start with a=0x00, b=0x00, cin=0 (WIDTH=8) -> done high exactly 9 cycles after the accept edge; sum=0x00, cout=0; busy high for 9 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0. Previous result must be held throughout the second RUN.
- a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Pulse start=1 with a=0x11 mid-RUN -> ignored; result unchanged; done pulses once.
- Hold start=1 for 40 cycles with a=0x03, b=0x04, cin=0 -> done pulses every 10 cycles; each sum=0x07, cout=0.
- Assert rst_n=0 at RUN cycle 4 of a=0xF0+0x0F -> busy, done, sum, cout go 0 asynchronously (before the next edge); no done pulse. Restart -> sum=0xFF, cout=0.
- WIDTH=3: exhaustive 128 combinations of {a,b,cin} -> every {cout,sum} matches a+b+cin; exactly one done per start.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell: a + b + cin -> {carry, sum}.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first, through a single
// full_adder cell with a registered carry; result is published with a done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  import adder_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic             fa_sum, fa_carry;
  logic             last_bit;

  full_adder u_fa (
    .a    (sha_q[0]),
    .b    (shb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    sha_d     = sha_q;
    shb_d     = shb_q;
    partial_d = partial_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sha_d     = a;
          shb_d     = b;
          carry_d   = cin;
          cnt_d     = '0;
          partial_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        sha_d     = sha_q >> 1;
        shb_d     = shb_q >> 1;
        partial_d = {fa_sum, partial_q[WIDTH-1:1]};
        carry_d   = fa_carry;
        cnt_d     = cnt_q + CNT_W'(1);
        // The last bit goes straight into the published result, bypassing partial.
        if (last_bit) begin
          sum_d   = {fa_sum, partial_q[WIDTH-1:1]};
          cout_d  = fa_carry;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sha_q     <= '0;
      shb_q     <= '0;
      partial_q <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sha_q     <= sha_d;
      shb_q     <= shb_d;
      partial_q <= partial_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder (WIDTH=8 and WIDTH=3 instances),
// checked against plain-arithmetic expectations of a + b + cin.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start3;
  logic [2:0] a3, b3;
  logic       cin3;
  logic       busy3, done3, cout3;
  logic [2:0] sum3;

  int vectors;
  int miscompares;

  serial_adder #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  // Issue one operation on the WIDTH=8 instance; lat = negedges from accept edge to done.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic c,
                        output int lat, output logic [8:0] res);
    @(negedge clk);
    start = 1'b1; a = x; b = y; cin = c;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = {cout, sum};
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_w8: got busy=%b done=%b cout=%b sum=%h, required all 0", busy, done, cout, sum);
    end
    vectors++;
    if ({busy3, done3, cout3, sum3} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_w3: got busy=%b done=%b cout=%b sum=%h, required all 0", busy3, done3, cout3, sum3);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    int busy_cnt, done_cnt, done_at;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    @(negedge clk);
    start = 1'b1; a = 8'h00; b = 8'h00; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = k;
        vectors++;
        if ({cout, sum} !== 9'h000) begin
          miscompares++;
          $display("FAIL zero_sum: got %h, required 000", {cout, sum});
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (done_at !== 9) begin
      miscompares++;
      $display("FAIL done_latency: got cycle %0d, required 9", done_at);
    end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++;
      $display("FAIL done_count: got %0d, required 1", done_cnt);
    end
    vectors++;
    if (busy_cnt !== 9) begin
      miscompares++;
      $display("FAIL busy_cycles: got %0d, required 9", busy_cnt);
    end
  endtask

  task automatic test_carry_hold();
    int lat;
    logic [8:0] res, held, exp;
    held = model8(8'hFF, 8'h01, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, lat, res);
    vectors++;
    if (res !== held) begin
      miscompares++;
      $display("FAIL carry_out: got %h, required %h", res, held);
    end
    exp = model8(8'h7F, 8'h01, 1'b0);
    @(negedge clk);
    start = 1'b1; a = 8'h7F; b = 8'h01; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      vectors++;
      if ({done, cout, sum} !== {1'b0, held}) begin
        miscompares++;
        $display("FAIL hold_during_run: cycle %0d got done=%b res=%h, required done=0 res=%h",
                 k, done, {cout, sum}, held);
      end
      @(negedge clk);
    end
    vectors++;
    if ({done, cout, sum} !== {1'b1, exp}) begin
      miscompares++;
      $display("FAIL second_result: got done=%b res=%h, required done=1 res=%h", done, {cout, sum}, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int done_cnt;
    logic [8:0] exp, got;
    exp = model8(8'hA5, 8'h5A, 1'b1);
    done_cnt = 0; got = '0;
    @(negedge clk);
    start = 1'b1; a = 8'hA5; b = 8'h5A; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
      end else if (k == 4) begin
        start = 1'b0; a = 8'hEE;
      end
      if (done === 1'b1) begin
        done_cnt++;
        got = {cout, sum};
      end
      @(negedge clk);
    end
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL ignore_start_result: got %h, required %h", got, exp);
    end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++;
      $display("FAIL ignore_start_done_count: got %0d, required 1", done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int done_cnt, last_at;
    logic [8:0] exp;
    exp = model8(8'h03, 8'h04, 1'b0);
    done_cnt = 0; last_at = -1;
    @(negedge clk);
    start = 1'b1; a = 8'h03; b = 8'h04; cin = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        vectors++;
        if ({cout, sum} !== exp) begin
          miscompares++;
          $display("FAIL b2b_result: cycle %0d got %h, required %h", k, {cout, sum}, exp);
        end
        vectors++;
        if (k - last_at !== 10 && last_at != -1) begin
          miscompares++;
          $display("FAIL b2b_spacing: got %0d cycles, required 10", k - last_at);
        end
        last_at = k;
      end
    end
    start = 1'b0;
    vectors++;
    if (done_cnt !== 4) begin
      miscompares++;
      $display("FAIL b2b_done_count: got %0d, required 4", done_cnt);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, done_cnt;
    logic [8:0] res, exp;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1; a = 8'hF0; b = 8'h0F; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_run_busy: got %b, required 1", busy);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      miscompares++;
      $display("FAIL async_reset: got busy=%b done=%b cout=%b sum=%h, required all 0", busy, done, cout, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
      @(negedge clk);
    end
    vectors++;
    if (done_cnt !== 0) begin
      miscompares++;
      $display("FAIL post_abort_activity: got %0d active cycles, required 0", done_cnt);
    end
    exp = model8(8'hF0, 8'h0F, 1'b0);
    run_op(8'hF0, 8'h0F, 1'b0, lat, res);
    vectors++;
    if (res !== exp) begin
      miscompares++;
      $display("FAIL restart_result: got %h, required %h", res, exp);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [8:0] res, exp;
    logic [7:0] x, y;
    logic c;
    for (int n = 0; n < 40; n++) begin
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      exp = model8(x, y, c);
      run_op(x, y, c, lat, res);
      vectors++;
      if (res !== exp || lat !== 9) begin
        miscompares++;
        $display("FAIL random_op: %h+%h+%b got res=%h lat=%0d, required res=%h lat=9", x, y, c, res, lat, exp);
      end
    end
  endtask

  task automatic test_exhaustive_w3();
    int done_cnt;
    logic [3:0] got, exp;
    for (int i = 0; i < 128; i++) begin
      done_cnt = 0; got = '0;
      exp = {1'b0, 3'(i)} + {1'b0, 3'(i >> 3)} + {3'd0, 1'(i >> 6)};
      @(negedge clk);
      start3 = 1'b1; a3 = 3'(i); b3 = 3'(i >> 3); cin3 = 1'(i >> 6);
      @(negedge clk);
      start3 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        if (done3 === 1'b1) begin
          done_cnt++;
          got = {cout3, sum3};
        end
        @(negedge clk);
      end
      vectors++;
      if (got !== exp || done_cnt !== 1) begin
        miscompares++;
        $display("FAIL w3_exhaustive: a=%0d b=%0d cin=%0d got res=%h dones=%0d, required res=%h dones=1",
                 3'(i), 3'(i >> 3), 1'(i >> 6), got, done_cnt, exp);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_latency();
    test_carry_hold();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    test_exhaustive_w3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
